// File: rtl/key_pkg.sv
// Shared types and sizes for the HID key-slot event scheduler.
package key_pkg;

   localparam int NUM_SLOTS  = 6;
   localparam int SC_W       = 9;
   localparam int FIFO_DEPTH = 8;
   localparam int SLOT_W     = $clog2(NUM_SLOTS);

   // Per-slot tracker state: a slot is either quiet or owes the stream an event.
   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      BREAK_PEND = 2'd1,
      MAKE_PEND  = 2'd2
   } slot_state_t;

   // One serialized key event as stored in the event FIFO.
   typedef struct packed {
      logic              pressed;
      logic [SLOT_W-1:0] slot;
      logic [SC_W-1:0]   code;
   } key_evt_t;

   // Cyclic successor of a slot index (NUM_SLOTS need not be a power of 2).
   function automatic logic [SLOT_W-1:0] next_slot(input logic [SLOT_W-1:0] s);
      return (s == SLOT_W'(NUM_SLOTS - 1)) ? '0 : s + 1'b1;
   endfunction

endpackage

// File: rtl/key_evt_fifo.sv
// Synchronous first-word-fall-through FIFO of key events.
// The head is presented combinationally and forced to zero while empty.
import key_pkg::*;

module key_evt_fifo #(
   parameter int DEPTH = FIFO_DEPTH
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       push,
   input  key_evt_t                   push_data,
   input  logic                       pop,
   output key_evt_t                   head,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   key_evt_t        mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic            do_push;
   logic            do_pop;

   // A push is refused at full even if a pop happens in the same cycle.
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);
   assign head  = empty ? '0 : mem[rd_ptr];

   // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is a power of 2).
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage array; contents are don't-care until written, the head mux hides them.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/key_slot_sched.sv
// Watches every HID report slot, turns slot changes into make/break events,
// round-robin arbitrates them into an event FIFO and serves a valid/ready consumer.
import key_pkg::*;

module key_slot_sched (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [NUM_SLOTS*SC_W-1:0] slot_scancode,
   output logic                      ev_valid,
   input  logic                      ev_ready,
   output logic                      ev_pressed,
   output logic [SC_W-1:0]           ev_code,
   output logic [SLOT_W-1:0]         ev_slot,
   output logic                      busy
);

   // Handshake: ev_valid means the FIFO head is on ev_pressed/ev_code/ev_slot;
   // the head is consumed at a rising edge where ev_valid && ev_ready, and it
   // stays stable while ev_valid is high and ev_ready is low. ev_* read 0 when
   // ev_valid is low.

   // Per-slot debug view of tracker state, snapshot and previous code.
   slot_state_t         slot_state [NUM_SLOTS];
   logic [SC_W-1:0]     slot_snap  [NUM_SLOTS];
   logic [SC_W-1:0]     slot_old   [NUM_SLOTS];
   logic [NUM_SLOTS-1:0] slot_req;
   logic [NUM_SLOTS-1:0] slot_gnt;

   logic [SLOT_W-1:0]   rr_ptr;
   logic                gnt_valid;
   logic [SLOT_W-1:0]   gnt_idx;
   logic                gnt_ok;
   key_evt_t            push_evt;

   key_evt_t            fifo_head;
   logic                fifo_full;
   logic                fifo_empty;
   logic [$clog2(FIFO_DEPTH):0] fifo_count;

   for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
      slot_state_t     state_q, state_nxt;
      logic [SC_W-1:0] snap_q, snap_nxt;
      logic [SC_W-1:0] old_q, old_nxt;
      logic [SC_W-1:0] cur_code;

      assign cur_code      = slot_scancode[i*SC_W +: SC_W];
      assign slot_state[i] = state_q;
      assign slot_snap[i]  = snap_q;
      assign slot_old[i]   = old_q;
      assign slot_req[i]   = (state_q != IDLE);

      // Next-state: sample the slot only when idle; owe a break for a previous
      // non-empty code, then a make for a non-empty new code.
      always_comb begin
         state_nxt = state_q;
         snap_nxt  = snap_q;
         old_nxt   = old_q;
         case (state_q)
            IDLE: begin
               if (cur_code != snap_q) begin
                  old_nxt   = snap_q;
                  snap_nxt  = cur_code;
                  state_nxt = (snap_q != '0) ? BREAK_PEND : MAKE_PEND;
               end
            end
            BREAK_PEND: begin
               if (slot_gnt[i]) state_nxt = (snap_q != '0) ? MAKE_PEND : IDLE;
            end
            MAKE_PEND: begin
               if (slot_gnt[i]) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
         endcase
      end

      // Slot tracker registers; reset clears the snapshot so held keys re-make.
      always_ff @(posedge clk) begin
         if (!reset_n) begin
            state_q <= IDLE;
            snap_q  <= '0;
            old_q   <= '0;
         end else begin
            state_q <= state_nxt;
            snap_q  <= snap_nxt;
            old_q   <= old_nxt;
         end
      end
   end

   // Round-robin search: first requesting slot at or after rr_ptr, cyclically.
   always_comb begin : arb
      int idx;
      gnt_valid = 1'b0;
      gnt_idx   = '0;
      idx       = 0;
      for (int k = 0; k < NUM_SLOTS; k++) begin
         idx = int'(rr_ptr) + k;
         if (idx >= NUM_SLOTS) idx = idx - NUM_SLOTS;
         if (!gnt_valid && slot_req[idx]) begin
            gnt_valid = 1'b1;
            gnt_idx   = SLOT_W'(idx);
         end
      end
   end

   // A grant is only issued when the FIFO can take the event this cycle.
   always_comb begin
      gnt_ok   = gnt_valid && !fifo_full;
      slot_gnt = '0;
      if (gnt_ok) slot_gnt[gnt_idx] = 1'b1;
   end

   // Build the event for the granted slot: break carries the old code, make the snapshot.
   always_comb begin
      push_evt.slot    = gnt_idx;
      push_evt.pressed = (slot_state[gnt_idx] == MAKE_PEND);
      push_evt.code    = push_evt.pressed ? slot_snap[gnt_idx] : slot_old[gnt_idx];
   end

   // Round-robin pointer moves past the slot that was just served.
   always_ff @(posedge clk) begin
      if (!reset_n) rr_ptr <= '0;
      else if (gnt_ok) rr_ptr <= next_slot(gnt_idx);
   end

   key_evt_fifo #(
      .DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .reset_n  (reset_n),
      .push     (gnt_ok),
      .push_data(push_evt),
      .pop      (ev_ready),
      .head     (fifo_head),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .count    (fifo_count)
   );

   assign ev_valid   = !fifo_empty;
   assign ev_pressed = fifo_head.pressed;
   assign ev_code    = fifo_head.code;
   assign ev_slot    = fifo_head.slot;
   assign busy       = (|slot_req) || (fifo_count != '0);

endmodule

// File: tb/tb_key_slot_sched.sv
// Directed and randomized checks of the key slot scheduler against a
// per-slot make/break model of the HID report changes.
module tb_key_slot_sched;
   import key_pkg::*;

   localparam int EW = 1 + SLOT_W + SC_W;

   // ---------------- clock / reset ----------------
   logic                      clk = 1'b0;
   logic                      reset_n = 1'b0;
   logic [NUM_SLOTS*SC_W-1:0] slot_scancode = '0;
   logic                      ev_ready = 1'b1;
   logic                      ev_valid;
   logic                      ev_pressed;
   logic [SC_W-1:0]           ev_code;
   logic [SLOT_W-1:0]         ev_slot;
   logic                      busy;

   always #5 clk = ~clk;

   key_slot_sched dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .slot_scancode(slot_scancode),
      .ev_valid     (ev_valid),
      .ev_ready     (ev_ready),
      .ev_pressed   (ev_pressed),
      .ev_code      (ev_code),
      .ev_slot      (ev_slot),
      .busy         (busy)
   );

   // ---------------- scoreboard ----------------
   int total = 0;
   int bad   = 0;
   logic [EW-1:0] exp_q [$];
   logic [EW-1:0] rx_q  [$];
   logic [SC_W-1:0] model_code [NUM_SLOTS];

   // Monitor: record every accepted event, sampled on the falling edge.
   always @(negedge clk) begin
      if (reset_n && ev_valid && ev_ready) rx_q.push_back({ev_pressed, ev_slot, ev_code});
   end

   function automatic logic [EW-1:0] evt(input logic p, input int s, input logic [SC_W-1:0] c);
      return {p, SLOT_W'(s), c};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_slot(input int s, input logic [SC_W-1:0] code);
      slot_scancode[s*SC_W +: SC_W] = code;
   endtask

   task automatic reset_all_zero();
      slot_scancode = '0;
      reset_n = 1'b0;
      tick(2);
      reset_n = 1'b1;
      rx_q.delete();
      exp_q.delete();
      for (int s = 0; s < NUM_SLOTS; s++) model_code[s] = '0;
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      tick(1);
      while (busy === 1'b1 && n < 2000) begin
         tick(1);
         n++;
      end
      check({tag, "_idle"}, {31'b0, busy}, 32'd0);
   endtask

   task automatic compare_q(input string tag);
      int n;
      check({tag, "_count"}, rx_q.size(), exp_q.size());
      n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) check({tag, "_evt"}, rx_q[i], exp_q[i]);
      rx_q.delete();
      exp_q.delete();
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [SC_W-1:0] c [NUM_SLOTS];
      logic [SC_W-1:0] d0, d1, nc, rs, es;
      logic [EW-1:0]   rx, ee;
      int              idx, n;

      reset_all_zero();
      check("rst_valid", {31'b0, ev_valid}, 0);
      check("rst_busy", {31'b0, busy}, 0);
      check("rst_head", {ev_pressed, ev_slot, ev_code}, 0);

      // Quiet report: nothing must come out.
      for (int i = 0; i < 20; i++) begin
         tick(1);
         check("quiet_valid", {31'b0, ev_valid}, 0);
         check("quiet_busy", {31'b0, busy}, 0);
      end

      // Single make with latency check.
      set_slot(0, 9'h01C);
      tick(1);
      check("lat1_valid", {31'b0, ev_valid}, 0);
      check("lat1_busy", {31'b0, busy}, 1);
      tick(1);
      check("lat2_valid", {31'b0, ev_valid}, 1);
      check("lat2_head", {ev_pressed, ev_slot, ev_code}, evt(1'b1, 0, 9'h01C));
      exp_q.push_back(evt(1'b1, 0, 9'h01C));
      wait_idle("make0");
      compare_q("make0");

      // Code swap on slot 2: break old then make new, then release.
      set_slot(2, 9'h01C);
      exp_q.push_back(evt(1'b1, 2, 9'h01C));
      wait_idle("s2a");
      set_slot(2, 9'h032);
      exp_q.push_back(evt(1'b0, 2, 9'h01C));
      exp_q.push_back(evt(1'b1, 2, 9'h032));
      wait_idle("s2b");
      set_slot(2, 9'h000);
      exp_q.push_back(evt(1'b0, 2, 9'h032));
      wait_idle("s2c");
      compare_q("swap2");

      // Simultaneous makes from rr_ptr 0: order 0,3,5.
      reset_all_zero();
      set_slot(0, 9'h01C); set_slot(3, 9'h023); set_slot(5, 9'h02B);
      exp_q.push_back(evt(1'b1, 0, 9'h01C));
      exp_q.push_back(evt(1'b1, 3, 9'h023));
      exp_q.push_back(evt(1'b1, 5, 9'h02B));
      wait_idle("rr0");
      compare_q("rr0");
      // Release all three together (pointer back at 0 after slot 5), then
      // toggle slot 3 alone so the pointer lands on 4.
      set_slot(0, 9'h000); set_slot(3, 9'h000); set_slot(5, 9'h000);
      exp_q.push_back(evt(1'b0, 0, 9'h01C));
      exp_q.push_back(evt(1'b0, 3, 9'h023));
      exp_q.push_back(evt(1'b0, 5, 9'h02B));
      wait_idle("rrrel");
      set_slot(3, 9'h023);
      exp_q.push_back(evt(1'b1, 3, 9'h023));
      wait_idle("rr3a");
      set_slot(3, 9'h000);
      exp_q.push_back(evt(1'b0, 3, 9'h023));
      wait_idle("rr3b");
      compare_q("rrprep");
      set_slot(0, 9'h01C); set_slot(3, 9'h023); set_slot(5, 9'h02B);
      exp_q.push_back(evt(1'b1, 5, 9'h02B));
      exp_q.push_back(evt(1'b1, 0, 9'h01C));
      exp_q.push_back(evt(1'b1, 3, 9'h023));
      wait_idle("rr4");
      compare_q("rr4");

      // Backpressure: fill the FIFO and leave two events pending in the slots.
      reset_all_zero();
      ev_ready = 1'b0;
      for (int s = 0; s < NUM_SLOTS; s++) begin
         c[s] = SC_W'($urandom_range(1, 511));
         set_slot(s, c[s]);
         exp_q.push_back(evt(1'b1, s, c[s]));
      end
      tick(10);
      d0 = (c[0] % 9'd511) + 9'd1;
      d1 = (c[1] % 9'd511) + 9'd1;
      set_slot(0, d0); set_slot(1, d1);
      exp_q.push_back(evt(1'b0, 0, c[0]));
      exp_q.push_back(evt(1'b0, 1, c[1]));
      exp_q.push_back(evt(1'b1, 0, d0));
      exp_q.push_back(evt(1'b1, 1, d1));
      tick(10);
      check("full_valid", {31'b0, ev_valid}, 1);
      check("full_busy", {31'b0, busy}, 1);
      check("full_head", {ev_pressed, ev_slot, ev_code}, evt(1'b1, 0, c[0]));
      tick(5);
      check("full_hold", {ev_pressed, ev_slot, ev_code}, evt(1'b1, 0, c[0]));
      check("full_rx", rx_q.size(), 0);
      ev_ready = 1'b1;
      wait_idle("full");
      compare_q("full");

      // Reset while events are queued: held key re-makes exactly once.
      reset_all_zero();
      ev_ready = 1'b0;
      set_slot(1, 9'h045);
      tick(3);
      set_slot(1, 9'h01C);
      tick(5);
      check("mrst_pre", {ev_valid, ev_pressed, ev_slot, ev_code}, {1'b1, evt(1'b1, 1, 9'h045)});
      reset_n = 1'b0;
      tick(1);
      reset_n = 1'b1;
      check("mrst_valid", {31'b0, ev_valid}, 0);
      check("mrst_busy", {31'b0, busy}, 0);
      check("mrst_head", {ev_pressed, ev_slot, ev_code}, 0);
      rx_q.delete();
      ev_ready = 1'b1;
      exp_q.push_back(evt(1'b1, 1, 9'h01C));
      wait_idle("mrst");
      compare_q("mrst");

      // Randomized rounds: per-slot order must follow the make/break rule,
      // with random consumer backpressure.
      reset_all_zero();
      for (int r = 0; r < 25; r++) begin
         for (int s = 0; s < NUM_SLOTS; s++) begin
            if ($urandom_range(0, 1) == 1) begin
               nc = ($urandom_range(0, 3) == 0) ? '0 : SC_W'($urandom_range(1, 511));
               if (nc != model_code[s]) begin
                  if (model_code[s] != '0) exp_q.push_back(evt(1'b0, s, model_code[s]));
                  if (nc != '0) exp_q.push_back(evt(1'b1, s, nc));
                  model_code[s] = nc;
                  set_slot(s, nc);
               end
            end
         end
         tick(1);
         n = 0;
         while (busy === 1'b1 && n < 3000) begin
            ev_ready = ($urandom_range(0, 1) == 1);
            if (ev_valid === 1'b0) check("rnd_zero", {ev_pressed, ev_slot, ev_code}, 0);
            tick(1);
            n++;
         end
         ev_ready = 1'b1;
         check("rnd_idle", {31'b0, busy}, 0);
         for (int k = 0; k < rx_q.size(); k++) begin
            rx  = rx_q[k];
            rs  = SC_W'(rx[SC_W +: SLOT_W]);
            idx = -1;
            for (int j = 0; j < exp_q.size(); j++) begin
               ee = exp_q[j];
               es = SC_W'(ee[SC_W +: SLOT_W]);
               if (idx < 0 && es == rs) idx = j;
            end
            check("rnd_found", {31'b0, (idx >= 0)}, 1);
            if (idx >= 0) begin
               check("rnd_evt", rx, exp_q[idx]);
               exp_q.delete(idx);
            end
         end
         check("rnd_left", exp_q.size(), 0);
         rx_q.delete();
         exp_q.delete();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
